// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and FSM state type for the BCD <-> Excess-3
// sequential converter (conv_bcd_e3_seq) and its single-digit mapper
// (conv_digit).
//   MODE_*      : values of the mode input (direction of conversion)
//   E3_OFFSET   : distance between an 8421 digit and its Excess-3 code
//   BCD_MAX,
//   E3_MIN/MAX  : legal code-point ranges of each representation
//   conv_state_e: converter FSM states
package conv_pkg;

  localparam logic       MODE_8421_TO_E3 = 1'b0;
  localparam logic       MODE_E3_TO_8421 = 1'b1;

  localparam logic [3:0] E3_OFFSET = 4'd3;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] E3_MIN  = 4'd3;
  localparam logic [3:0] E3_MAX  = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

endpackage

// File: rtl/conv_digit.sv
// conv_digit: combinational single-digit mapper between 8421 BCD and
// Excess-3. Illegal code points map to 4'b0000.
// Ports:
//   mode      in  0: 8421 -> Excess-3, 1: Excess-3 -> 8421
//   digit_in  in  source digit
//   digit_out out converted digit
//   illegal   out source digit is not a legal code point for this mode
// Build option: CONV_ERR_FLAG_EN -- when undefined, illegal is tied to 0
// (the 0000 substitution for illegal digits is kept in both builds).
module conv_digit
  import conv_pkg::*;
(
  input  logic       mode,
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out,
  output logic       illegal
);

  logic legal;

  always_comb begin
    legal     = 1'b0;
    digit_out = 4'b0000;
    if (mode == MODE_8421_TO_E3) begin
      legal = (digit_in <= BCD_MAX);
      if (legal) digit_out = digit_in + E3_OFFSET;
    end else begin
      legal = (digit_in >= E3_MIN) && (digit_in <= E3_MAX);
      if (legal) digit_out = digit_in - E3_OFFSET;
    end
  end

`ifdef CONV_ERR_FLAG_EN
  assign illegal = ~legal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: rtl/conv_bcd_e3_seq.sv
// conv_bcd_e3_seq: sequential multi-digit 8421 BCD <-> Excess-3 converter.
// One shared conv_digit mapper converts one digit per clock.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   in_valid   din/mode valid       in_ready  converter can take a word
//   mode       direction, sampled with din
//   din        packed source digits, digit 0 in bits [3:0]
//   out_valid  dout/err valid       out_ready consumer accepts dout
//   dout       packed converted digits
//   err        at least one digit of the word was illegal
//   dbg_state  current FSM state (observation only)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready/out_valid depend only on the registered state, so there
// is no combinational path from in_valid or out_ready. A producer whose
// word is not taken must hold it stable until it is.
// Build option: CONV_ERR_FLAG_EN enables illegal-digit reporting on err;
// without it err stays 0.
module conv_bcd_e3_seq
  import conv_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] din,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] dout,
  output logic                err,
  output conv_state_e         dbg_state
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  conv_state_e     state, state_nxt;
  logic [W-1:0]    din_q;
  logic            mode_q;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    result;
  logic [W-1:0]    result_nxt;
  logic            err_acc;
  logic [W-1:0]    dout_q;
  logic            err_q;
  logic [3:0]      cur_digit;
  logic [3:0]      dig_out;
  logic            dig_illegal;
  logic            accept;
  logic            last;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (idx == IDXW'(DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV;
      end
      CONV: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select digit idx of the latched word for the shared mapper.
  always_comb begin
    cur_digit = 4'b0000;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDXW'(i)) cur_digit = din_q[4*i +: 4];
    end
  end

  conv_digit u_digit (
    .mode      (mode_q),
    .digit_in  (cur_digit),
    .digit_out (dig_out),
    .illegal   (dig_illegal)
  );

  // Working result with the current digit merged in.
  always_comb begin
    result_nxt = result;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDXW'(i)) result_nxt[4*i +: 4] = dig_out;
    end
  end

  // The working register is separate from dout so the previous word stays
  // visible until the new one is complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q   <= '0;
      mode_q  <= MODE_8421_TO_E3;
      idx     <= '0;
      result  <= '0;
      err_acc <= 1'b0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      din_q   <= din;
      mode_q  <= mode;
      idx     <= '0;
      result  <= '0;
      err_acc <= 1'b0;
    end else if (state == CONV) begin
      result  <= result_nxt;
      err_acc <= err_acc | dig_illegal;
      idx     <= last ? '0 : idx + IDXW'(1);
      if (last) begin
        dout_q <= result_nxt;
        err_q  <= err_acc | dig_illegal;
      end
    end
  end

  assign dout      = dout_q;
  assign err       = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_conv_bcd_e3_seq.sv
// tb_conv_bcd_e3_seq: self-checking bench for conv_bcd_e3_seq (DIGITS=4).
// Directed steps from the test plan followed by randomized words, checked
// by a scoreboard fed from a digit-by-digit arithmetic reference model.
// Honors CONV_ERR_FLAG_EN for the expected err value.
module tb_conv_bcd_e3_seq;
  import conv_pkg::*;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  logic         err;
  conv_state_e  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  conv_bcd_e3_seq #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  longint       acc_t_q[$];
  longint       last_acc_t = 0;
  longint       prev_acc_t = 0;
  logic [W-1:0] last_dout  = '0;
  logic         last_err   = 1'b0;
  logic         ov_prev    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: each nibble converted on its own with integer math.
  task automatic model(input logic m, input logic [W-1:0] d,
                       output logic [W-1:0] q, output logic e);
    int v;
    int r;
    q = '0;
    e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      v = int'((d >> (4 * i)) & W'(15));
      if (m == 1'b0) begin
        if (v <= 9) r = v + 3;
        else begin r = 0; e = 1'b1; end
      end else begin
        if (v >= 3 && v <= 12) r = v - 3;
        else begin r = 0; e = 1'b1; end
      end
      q = q | (W'(r) << (4 * i));
    end
`ifndef CONV_ERR_FLAG_EN
    e = 1'b0;
`endif
  endtask

  // Output monitor: sampled on the falling edge, inputs change just after
  // the rising edge, so out_ready seen here holds through the next edge.
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (in_ready && out_valid) check("ready_valid_exclusive", 32'(1), 32'(0));
      if (out_valid && !ov_prev) begin
        if (acc_t_q.size() == 0) begin
          check("spurious_out_valid", 32'(1), 32'(0));
        end else begin
          longint t0;
          t0 = acc_t_q.pop_front();
          check("latency", 32'(($time - t0 - 5) / 10), 32'(DIGITS));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(1), 32'(0));
        end else begin
          check("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
          check("sb_err", 32'(err), 32'(exp_err_q.pop_front()));
        end
        last_dout = dout;
        last_err  = err;
      end
      ov_prev = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic present(input logic m, input logic [W-1:0] d);
    @(posedge clk); #1;
    in_valid = 1'b1;
    mode     = m;
    din      = d;
  endtask

  task automatic wait_accept();
    int n;
    logic [W-1:0] q;
    logic e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 100), 32'(1));
    @(posedge clk);
    prev_acc_t = last_acc_t;
    last_acc_t = $time;
    acc_t_q.push_back($time);
    model(mode, din, q, e);
    exp_q.push_back(q);
    exp_err_q.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic accept_word(input logic m, input logic [W-1:0] d);
    present(m, d);
    wait_accept();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_wait", 32'(n < 200), 32'(1));
    #1;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_wait", 32'(n < 100), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random steps ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    mode      = 1'b0;
    din       = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_dout", 32'(dout), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // 8421 -> Excess-3
    accept_word(1'b0, 16'h1234);
    wait_drain();
    check("t1_dout", 32'(last_dout), 32'h4567);
    check("t1_err", 32'(last_err), 32'(0));

    // Excess-3 -> 8421
    accept_word(1'b1, 16'hC3A5);
    wait_drain();
    check("t2_dout", 32'(last_dout), 32'h9072);
    check("t2_err", 32'(last_err), 32'(0));

    // Illegal digit in mode 0
    accept_word(1'b0, 16'h12A9);
    wait_drain();
    check("t3_dout", 32'(last_dout), 32'h450C);
`ifdef CONV_ERR_FLAG_EN
    check("t3_err", 32'(last_err), 32'(1));
`else
    check("t3_err", 32'(last_err), 32'(0));
`endif

    // Backpressure with a second word waiting
    out_ready = 1'b0;
    accept_word(1'b0, 16'h0987);
    wait_out_valid();
    present(1'b1, 16'h3456);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_dout", 32'(dout), 32'h3CBA);
      check("bp_err", 32'(err), 32'(0));
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_state", 32'(dbg_state), 32'(DONE));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    wait_drain();
    check("bp_second_dout", 32'(last_dout), 32'h0123);
    check("bp_second_err", 32'(last_err), 32'(0));

    // Reset after two conversion cycles
    accept_word(1'b0, 16'h5555);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_err_q.delete();
    acc_t_q.delete();
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_dout", 32'(dout), 32'(0));
    check("mid_rst_err", 32'(err), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < DIGITS + 2; k++) begin
      @(negedge clk);
      check("post_rst_no_pulse", 32'(out_valid), 32'(0));
    end
    accept_word(1'b0, 16'h0099);
    wait_drain();
    check("post_rst_dout", 32'(last_dout), 32'h33CC);
    check("post_rst_err", 32'(last_err), 32'(0));

    // All-illegal word in mode 1
    accept_word(1'b1, 16'h0000);
    wait_drain();
    check("t6_dout", 32'(last_dout), 32'h0000);
`ifdef CONV_ERR_FLAG_EN
    check("t6_err", 32'(last_err), 32'(1));
`else
    check("t6_err", 32'(last_err), 32'(0));
`endif

    // Back-to-back accepts with in_valid held and out_ready high
    accept_word(1'b0, 16'h1111);
    accept_word(1'b1, 16'h4444);
    check("b2b_spacing", 32'((last_acc_t - prev_acc_t) / 10), 32'(DIGITS + 2));
    wait_drain();
    check("b2b_dout", 32'(last_dout), 32'h1111);

    // Randomized words with occasional output stalls
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] d;
      int stall;
      d = '0;
      for (int i = 0; i < DIGITS; i++) d[4*i +: 4] = 4'($urandom_range(0, 15));
      stall = int'($urandom_range(0, 3));
      out_ready = (stall == 0);
      accept_word(1'($urandom_range(0, 1)), d);
      if (stall != 0) begin
        wait_out_valid();
        repeat (stall) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      wait_drain();
    end

    repeat (3) @(posedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
